obi_resp_model: RTL
===================

OBI_RESP_MODEL -- requirements
Module: obi_resp_model

Interface
REQ-001 Parameters SHALL be: MAX_OUTSTANDING, default 2, maximum number of granted but unanswered transactions (range 1..4); GNT_TIMEOUT, default 4, maximum cycles a request waits for grant; RSP_TIMEOUT, default 4, maximum cycles the oldest transaction waits for rvalid.
REQ-002 The clock and reset SHALL be: clk_i in 1, single clock, all state on its rising edge; rst_ni in 1, asynchronous active-low reset.
REQ-003 The port list SHALL be:
- req_i in 1: core request
- addr_i in 32: request address
- we_i in 1: write enable
- be_i in 4: byte enables
- wdata_i in 32: write data
- gnt_o out 1: grant to core
- rvalid_o out 1: response valid to core
- rdata_o out 32: response data
- gnt_en_i in 1: free (solver-driven) grant permission
- rvalid_en_i in 1: free response permission
- rdata_src_i in 32: free response data
- outstanding_o out 3: current outstanding count
- resp_addr_o out 32: address of the transaction being answered
- resp_we_o out 1: we of the transaction being answered
- err_o out 1: sticky protocol violation flag

Function
REQ-004 Outstanding transactions SHALL be held in an in-order FIFO of depth MAX_OUTSTANDING storing {addr, we}.
REQ-005 gnt_o SHALL be combinational: req_i && (gnt_en_i || gnt_wait == GNT_TIMEOUT) && (count < MAX_OUTSTANDING || rvalid_o).
REQ-006 gnt_o SHALL never assert while req_i is low.
REQ-007 The model SHALL push onto the FIFO on each granted cycle.
REQ-008 rvalid_o SHALL be combinational: count > 0 && (rvalid_en_i || rsp_wait == RSP_TIMEOUT).
REQ-009 Minimum grant-to-rvalid latency SHALL be one cycle, because count is registered.
REQ-010 The model SHALL pop the FIFO head on each rvalid_o cycle; resp_addr_o and resp_we_o SHALL show the head entry.
REQ-011 rdata_o SHALL equal rdata_src_i when rvalid_o is high and resp_we_o is 0, and SHALL be 0 otherwise.
REQ-012 Simultaneous push and pop SHALL leave count unchanged, including at count == MAX_OUTSTANDING.
REQ-013 The FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-014 A push while full without a pop SHALL be impossible, as guaranteed by REQ-005.
REQ-015 gnt_wait SHALL increment (saturating at GNT_TIMEOUT) each cycle req_i is high and gnt_o is low.
REQ-016 gnt_wait SHALL clear on gnt_o or when req_i is low.
REQ-017 rsp_wait SHALL increment (saturating at RSP_TIMEOUT) each cycle count > 0 and rvalid_o is low.
REQ-018 rsp_wait SHALL clear on rvalid_o or when count == 0.
REQ-019 Request tracking SHALL have two states: IDLE and PEND.
- IDLE -> PEND when req_i is high and gnt_o is low; the model SHALL capture {addr_i, we_i, be_i, wdata_i}.
- PEND -> IDLE on gnt_o.
REQ-020 While in PEND, req_i low or any change of addr_i, we_i, be_i or wdata_i from the captured values SHALL set err_o.
REQ-021 err_o SHALL be sticky until reset.
REQ-022 outstanding_o SHALL equal count, width 3, range 0..MAX_OUTSTANDING.

Reset
REQ-023 Assertion of rst_ni low SHALL immediately clear the following, mid-transaction included:
- count, FIFO pointers, gnt_wait, rsp_wait
- state to IDLE
- err_o to 0
REQ-024 During reset, gnt_o, rvalid_o, rdata_o, resp_addr_o, resp_we_o and outstanding_o SHALL read 0.
REQ-025 The first grant after rst_ni rises SHALL be possible in the first clock edge's cycle; FIFO entries discarded by reset SHALL never be answered.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Single read: req_i=1, addr_i=0x1A000080, gnt_en_i=1 at cycle 0; rvalid_en_i=1, rdata_src_i=0x00000013 at cycle 1 -> gnt_o=1 at cycle 0; rvalid_o=1, rdata_o=0x00000013, resp_addr_o=0x1A000080 at cycle 1; outstanding_o goes 1 then 0.
- Back-to-back with full FIFO (MAX_OUTSTANDING=2): three grant-eligible requests, rvalid_en_i=0 -> two grants, then gnt_o=0 with outstanding_o=2; at cycle 2 rvalid_en_i=1 -> third grant in the same cycle, outstanding_o stays 2.
- Grant timeout: req_i=1, gnt_en_i=0 held (GNT_TIMEOUT=4) -> gnt_o=1 exactly on the 5th cycle of the request.
- Response timeout: one outstanding, rvalid_en_i=0 (RSP_TIMEOUT=4) -> rvalid_o=1 on the 5th cycle after grant.
- Write response: we_i=1, wdata_i=0xDEADBEEF, rdata_src_i=0xFFFFFFFF -> rvalid_o=1, resp_we_o=1, rdata_o=0.
- Protocol error and reset: addr_i changes from 0x100 to 0x104 while ungranted -> err_o=1 next cycle and held; then rst_ni=0 with 2 outstanding -> err_o=0, outstanding_o=0, rvalid_o=0 immediately.

Source files
------------

// File: rtl/obi_resp_model.sv
// ---------------------------------------------------------------------------
// obi_resp_model
// Behavioural responder for an OBI-style core data port. It grants requests
// and returns responses under the control of free permission inputs
// (gnt_en_i / rvalid_en_i). Timeout counters force a grant or a response
// once the permission has been withheld for too long. Granted transactions
// are answered strictly in order from a small {addr, we} FIFO. A sticky error
// flag reports a core that drops or alters a request before it is granted.
//
// Parameters
//   MAX_OUTSTANDING : granted but unanswered transactions allowed (1..4)
//   GNT_TIMEOUT     : cycles a request may wait before a forced grant
//   RSP_TIMEOUT     : cycles the oldest transaction may wait before a
//                     forced response
//
// Ports
//   clk_i, rst_ni      : clock and asynchronous active-low reset
//   req_i, addr_i, we_i, be_i, wdata_i : core request channel
//   gnt_o              : grant to the core (combinational)
//   rvalid_o, rdata_o  : response channel (combinational)
//   gnt_en_i, rvalid_en_i, rdata_src_i : free grant/response permissions
//                        and the response data source
//   outstanding_o      : number of granted, unanswered transactions
//   resp_addr_o, resp_we_o : FIFO head, i.e. the transaction being answered
//   err_o              : sticky protocol violation flag
// ---------------------------------------------------------------------------
module obi_resp_model #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int GNT_TIMEOUT     = 4,
  parameter int RSP_TIMEOUT     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        gnt_en_i,
  input  logic        rvalid_en_i,
  input  logic [31:0] rdata_src_i,
  output logic [2:0]  outstanding_o,
  output logic [31:0] resp_addr_o,
  output logic        resp_we_o,
  output logic        err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int GW = (GNT_TIMEOUT > 0) ? $clog2(GNT_TIMEOUT + 1) : 1;
  localparam int RW = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

  localparam logic [2:0]    MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [GW-1:0] GNT_SAT  = GW'(GNT_TIMEOUT);
  localparam logic [RW-1:0] RSP_SAT  = RW'(RSP_TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // Outstanding FIFO storage; entries are not reset because count and
  // pointers are, so stale entries can never reach the head as valid.
  logic [31:0]   r_fifo_addr [MAX_OUTSTANDING];
  logic          r_fifo_we   [MAX_OUTSTANDING];

  logic [2:0]    r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [GW-1:0] r_gnt_wait;
  logic [RW-1:0] r_rsp_wait;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_capture;
  logic          w_err_next;
  logic          r_err;
  logic [31:0]   r_cap_addr;
  logic          r_cap_we;
  logic [3:0]    r_cap_be;
  logic [31:0]   r_cap_wdata;

  logic          w_gnt;
  logic          w_rvalid;
  logic          w_nonempty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign w_nonempty = (r_count != 3'd0);

  // rst_ni gates the combinational handshakes so nothing is granted or
  // answered while reset is held, even with req_i / permissions high.
  assign w_rvalid = rst_ni && w_nonempty &&
                    (rvalid_en_i || (r_rsp_wait == RSP_SAT));

  // A full FIFO may still grant when the head is popped in the same cycle.
  assign w_gnt = rst_ni && req_i &&
                 (gnt_en_i || (r_gnt_wait == GNT_SAT)) &&
                 ((r_count < MAX_CNT) || w_rvalid);

  assign gnt_o         = w_gnt;
  assign rvalid_o      = w_rvalid;
  assign outstanding_o = r_count;
  assign resp_addr_o   = w_nonempty ? r_fifo_addr[r_rptr] : 32'd0;
  assign resp_we_o     = w_nonempty ? r_fifo_we[r_rptr]   : 1'b0;
  assign rdata_o       = (w_rvalid && !resp_we_o) ? rdata_src_i : 32'd0;
  assign err_o         = r_err;

  always_ff @(posedge clk_i) begin
    if (w_gnt) begin
      r_fifo_addr[r_wptr] <= addr_i;
      r_fifo_we[r_wptr]   <= we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= 3'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_gnt_wait <= '0;
      r_rsp_wait <= '0;
    end else begin
      case ({w_gnt, w_rvalid})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_gnt)    r_wptr <= ptr_inc(r_wptr);
      if (w_rvalid) r_rptr <= ptr_inc(r_rptr);

      if (req_i && !w_gnt) begin
        if (r_gnt_wait != GNT_SAT) r_gnt_wait <= r_gnt_wait + GW'(1);
      end else begin
        r_gnt_wait <= '0;
      end

      if (w_nonempty && !w_rvalid) begin
        if (r_rsp_wait != RSP_SAT) r_rsp_wait <= r_rsp_wait + RW'(1);
      end else begin
        r_rsp_wait <= '0;
      end
    end
  end

  // Request tracking: an ungranted request must stay asserted and stable.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (req_i && !w_gnt) begin
          w_state_next = ST_PEND;
          w_capture    = 1'b1;
        end
      end
      ST_PEND: begin
        if (!req_i || (addr_i != r_cap_addr) || (we_i != r_cap_we) ||
            (be_i != r_cap_be) || (wdata_i != r_cap_wdata)) begin
          w_err_next = 1'b1;
        end
        if (w_gnt) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_err       <= 1'b0;
      r_cap_addr  <= 32'd0;
      r_cap_we    <= 1'b0;
      r_cap_be    <= 4'd0;
      r_cap_wdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_capture) begin
        r_cap_addr  <= addr_i;
        r_cap_we    <= we_i;
        r_cap_be    <= be_i;
        r_cap_wdata <= wdata_i;
      end
    end
  end

endmodule
